// File: rtl/nibble_frame_serializer.sv
// Nibble-buffered frame serializer: collects up to 16 nibbles, then sends a
// start marker, the payload MSB-first (first-written nibble first) and a stop cycle.
module nibble_frame_serializer (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       clk;
    logic       rst;
    logic       wr;
    logic       go;
    logic [3:0] nib;

    assign clk = io_in[0];
    assign rst = io_in[1];
    assign wr  = io_in[2];
    assign go  = io_in[3];
    assign nib = io_in[7:4];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] buffer;
    logic [4:0]  count;
    logic [6:0]  bits_rem;
    logic [2:0]  bidx;
    logic [5:0]  wr_hi;
    logic        sdata;

    // Top bit of the next free slot; only used while count < 16.
    assign wr_hi = 6'd63 - {count[3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            buffer   <= '0;
            count    <= '0;
            bits_rem <= '0;
            bidx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        if (count != 5'd0) begin
                            bits_rem <= {count, 2'b00};
                            bidx     <= '0;
                            state    <= START;
                        end
                    end else if (wr && !count[4]) begin
                        buffer[wr_hi -: 4] <= nib;
                        count              <= count + 5'd1;
                    end
                end
                START: begin
                    state <= DATA;
                end
                DATA: begin
                    buffer   <= {buffer[62:0], 1'b0};
                    bits_rem <= bits_rem - 7'd1;
                    bidx     <= bidx + 3'd1;
                    // Last payload bit is on the line; leave with bidx parked at 0.
                    if (bits_rem == 7'd1) begin
                        state <= STOP;
                        bidx  <= '0;
                    end
                end
                STOP: begin
                    state  <= IDLE;
                    buffer <= '0;
                    count  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sdata = (state == START) || ((state == DATA) && buffer[63]);

    assign io_out = {bidx,
                     (count == 5'd16),
                     (state != IDLE),
                     (state == START),
                     (state == DATA),
                     sdata};

endmodule

// File: tb/tb_nibble_frame_serializer.sv
// Directed bench for nibble_frame_serializer: a nibble model builds the expected
// payload queue on go, and each valid cycle pops and checks one {sdata, bidx} entry.
module tb_nibble_frame_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       go  = 1'b0;
    logic [3:0] nib = 4'h0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {nib, go, wr, rst, clk};

    nibble_frame_serializer dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];   // {sdata, bidx[2:0]} per payload bit
    logic [3:0] mq[$];      // nibbles held by the model buffer

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic cycle(input logic w, input logic g, input logic [3:0] n);
        wr  = w;
        go  = g;
        nib = n;
        @(negedge clk);
        wr  = 1'b0;
        go  = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] n);
        cycle(1'b1, 1'b0, n);
        if (mq.size() < 16) mq.push_back(n);
        check("write_idle", io_out, {3'b000, (mq.size() == 16), 4'b0000});
    endtask

    task automatic do_frame(input int abort_at, input bit noise);
        int         nb;
        logic       f;
        logic [3:0] e;
        logic [3:0] cur;
        logic [2:0] bi;
        nb = 0;
        f  = (mq.size() == 16);
        for (int i = 0; i < mq.size(); i++) begin
            cur = mq[i];
            for (int b = 3; b >= 0; b--) begin
                bi = nb[2:0];
                exp_q.push_back({cur[b], bi});
                nb++;
            end
        end
        check("start", io_out, {3'b000, f, 4'b1101});
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("data", io_out, {e[2:0], f, 3'b101, e[3]});
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_zero", io_out, 8'h00);
                exp_q.delete();
                mq.delete();
                return;
            end
            if (noise && i == 2) begin wr = 1'b1; go = 1'b0; nib = 4'hF; end
            if (noise && i == 3) begin wr = 1'b0; go = 1'b1; nib = 4'h0; end
            if (noise && i == 4) begin wr = 1'b1; go = 1'b1; nib = 4'h6; end
            if (noise && i == 5) begin wr = 1'b0; go = 1'b0; end
        end
        @(negedge clk);
        check("stop", io_out, {3'b000, f, 4'b1000});
        @(negedge clk);
        check("idle_after", io_out, 8'h00);
        mq.delete();
    endtask

    task automatic do_go(input logic w, input logic [3:0] n, input int abort_at, input bit noise);
        cycle(w, 1'b1, n);
        if (mq.size() == 0) check("go_empty", io_out, 8'h00);
        else do_frame(abort_at, noise);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 4'h9);
        cycle(1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        check("reset", io_out, 8'h00);

        // go with nothing buffered
        do_go(1'b0, 4'h0, -1, 1'b0);

        // full 16-nibble frame 0x123456789ABCDEF0
        for (int k = 1; k < 16; k++) do_write(4'(k));
        do_write(4'h0);
        do_go(1'b0, 4'h0, -1, 1'b0);

        // two-nibble frame, busy for exactly 10 cycles
        do_write(4'hA);
        do_write(4'h5);
        do_go(1'b0, 4'h0, -1, 1'b0);

        // 17th write while full is dropped
        for (int k = 0; k < 16; k++) do_write(4'($urandom_range(0, 15)));
        do_write(4'($urandom_range(0, 15)));
        do_go(1'b0, 4'h0, -1, 1'b0);

        // wr and go together: go wins, nibble 7 discarded
        do_write(4'hC);
        do_go(1'b1, 4'h7, -1, 1'b0);

        // wr/go noise during DATA, then count must be back to 0
        do_write(4'h3);
        do_write(4'h9);
        do_go(1'b0, 4'h0, -1, 1'b1);
        do_go(1'b0, 4'h0, -1, 1'b0);

        // reset at payload bit 20 of a full frame, then a clean 2-nibble frame
        for (int k = 0; k < 16; k++) do_write(4'($urandom_range(0, 15)));
        do_go(1'b0, 4'h0, 20, 1'b0);
        do_write(4'($urandom_range(0, 15)));
        do_write(4'($urandom_range(0, 15)));
        do_go(1'b0, 4'h0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_frame_serializer.md
NIBBLE_FRAME_SERIALIZER -- requirements
Module: nibble_frame_serializer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, both carried on the 8-bit io_in bus as in every user module.
REQ-002 io_in[0]  input  1  clock; all state changes on its rising edge.
REQ-003 io_in[1]  input  1  reset; synchronous, active-high.
REQ-004 io_in[2]  input  1  wr: nibble write strobe, level-sampled, one nibble per edge.
REQ-005 io_in[3]  input  1  go: start-transmission request, level-sampled.
REQ-006 io_in[7:4]  input  4  nib: nibble data written when wr is accepted.
REQ-007 io_out[0]  output  1  sdata: serial data line.
REQ-008 io_out[1]  output  1  valid: high while sdata carries a payload bit.
REQ-009 io_out[2]  output  1  frame: high for the single start-marker cycle.
REQ-010 io_out[3]  output  1  busy: high from start marker through stop cycle.
REQ-011 io_out[4]  output  1  full: nibble count equals 16.
REQ-012 io_out[7:5]  output  3  bidx: bit index within the current payload byte.

Function
REQ-013 SHALL contain a 64-bit buffer (16 nibble slots), a 5-bit nibble count (0..16), a 7-bit bits-remaining counter, a 3-bit bidx counter and a 4-state FSM: IDLE, START, DATA, STOP.
REQ-014 All outputs SHALL be registered or decoded from registered state only; no combinational path from io_in to io_out.
REQ-015 In IDLE, wr=1, go=0 and count<16 SHALL write nib into buffer bits [63-4*count -: 4] and increment count.
REQ-016 wr SHALL be ignored when count=16 or state is not IDLE.
REQ-017 In IDLE, go=1 with count>0 SHALL load bits-remaining = 4*count and move to START; go with count=0 SHALL be ignored.
REQ-018 wr and go together in IDLE: go SHALL win; the nibble is discarded.
REQ-019 go outside IDLE SHALL be ignored.
REQ-020 START lasts 1 cycle: sdata=1, frame=1, valid=0, busy=1, bidx=0; then DATA.
REQ-021 DATA: sdata=buffer[63], valid=1, busy=1; each edge shifts buffer left by 1 (zero fill), decrements bits-remaining and increments bidx mod 8; DATA exits to STOP on the edge where bits-remaining reaches 0.
REQ-022 Payload order: first-written nibble first, MSB of each nibble first.
REQ-023 STOP lasts 1 cycle: sdata=0, valid=0, frame=0, busy=1, bidx=0; then IDLE with buffer=0 and count=0.
REQ-024 IDLE outputs: sdata=0, valid=0, frame=0, busy=0, bidx=0.
REQ-025 full SHALL equal (count==16) in all states; it is held through the frame and drops on entry to IDLE after STOP.
REQ-026 Latency: go sampled at edge k gives START after edge k, first payload bit after k+1, last after k+4N, STOP after k+4N+1 and IDLE after k+4N+2; busy is high for 4N+2 cycles.
REQ-027 Frames SHALL be back-to-back capable: a new write is accepted on the first IDLE edge.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, buffer=0, count=0, bits-remaining=0, bidx=0 and all io_out bits 0 after that edge, from any state.
REQ-029 reset SHALL take precedence over wr and go on the same edge.
REQ-030 A reset in mid-frame SHALL abort the frame with no STOP cycle; the remaining bits are lost.

Verification
REQ-031 Reset, write nibbles 1,2,...,F,0 -> full=1 after 16th write; go -> frame pulse, then 64 valid bits of 0x123456789ABCDEF0 MSB-first with bidx 0..7 repeating x8, then STOP, then full=0, busy=0.
REQ-032 Write A then 5, then go -> payload 1010_0101, bidx 0..7, busy high exactly 10 cycles.
REQ-033 go with count=0 -> busy stays 0 and all outputs 0; a 17th wr when full -> count stays 16 and the payload is unchanged.
REQ-034 wr=1, go=1 together with count=1 (nib C previously written, nib 7 on bus) -> 4-bit payload 1100 only.
REQ-035 wr and go pulses during DATA -> ignored; the frame completes unchanged and count=0 afterwards.
REQ-036 reset at payload bit 20 of a full frame -> all outputs 0 on the next cycle, full=0; a following 2-nibble frame transmits correctly.
